dmem_master: RTL and testbench
==============================

# dmem_master

Initiator-side data memory access sequencer for the multicycle 16-bit core. It takes one load or store request at a time from the control unit and turns it into the edge-strobed data-memory protocol: `dm_read` / `dm_wr` rising edges, 16-bit byte address, and little-endian 16-bit data. It handles byte stores by read-modify-write and returns load data sign- or zero-extended. It sits between the control FSM/register file and the data memory.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles that address/write data are held stable with strobes low before a strobe rises. Legal range ≥1.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req` input 1: start request; sampled only while `ready`=1.
- `ready` output 1: unit idle; accepts `req` this cycle.
- `op_store` input 1: 1 = store, 0 = load.
- `op_byte` input 1: 1 = byte access, 0 = 16-bit word access.
- `ld_signed` input 1: byte load only; 1 = sign-extend, 0 = zero-extend.
- `addr` input 16: byte address. Word = {mem[addr+1], mem[addr]}.
- `st_data` input 16: store data. Byte store uses [7:0].
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; access rejected.
- `ld_data` output 16: load result; valid from `done` until next acceptance.
- `dm_addr` output 16: memory address.
- `dm_wr_data` output 16: memory write data.
- `dm_read` output 1: read strobe; the memory samples on its rising edge.
- `dm_wr` output 1: write strobe; the memory writes on its rising edge.
- `dm_rdata` input 16: memory read data; stable after the `dm_read` rising edge.

## Operation
- States: IDLE, SETUP, RD_STB, RD_CAP, WR_SETUP, WR_STB, WR_HOLD, DONE.
- IDLE: `ready`=1. When `req`=1, latch `op_store`, `op_byte`, `ld_signed`, `addr` and `st_data`.
  - If `addr`==16'hFFFF: go to DONE with `err`=1. No strobe is issued, because addr+1 would leave the array.
  - Otherwise: drive `dm_addr` from the latched address and go to SETUP.
- SETUP: hold for `SETUP_CYCLES` cycles with strobes low.
  - Word store: `dm_wr_data`=`st_data`, then go to WR_STB.
  - Any load or byte store: go to RD_STB.
- RD_STB: `dm_read`=1 for exactly one cycle, then go to RD_CAP.
- RD_CAP: `dm_read`=0; capture `dm_rdata`.
  - Word load: `ld_data`=`dm_rdata`.
  - Byte load: `ld_data`={8{`dm_rdata[7]`}&`ld_signed`}, `dm_rdata[7:0]`}.
  - Loads go to DONE.
  - Byte store: merge register = {`dm_rdata[15:8]`, `st_data[7:0]`}, then go to WR_SETUP.
- WR_SETUP: `dm_wr_data`=merge register; hold for `SETUP_CYCLES` cycles, then go to WR_STB.
- WR_STB: `dm_wr`=1 for exactly one cycle, then go to WR_HOLD.
- WR_HOLD: `dm_wr`=0; `dm_addr` and `dm_wr_data` still held. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `dm_addr` and `dm_wr_data` change only in IDLE (on acceptance) or on the RD_CAP→WR_SETUP transition. They never change in the same cycle a strobe rises or is high.
- Never assert `dm_read` and `dm_wr` together. Each strobe is high for at most one cycle per access.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `ready`=1. `done`, `err`, `dm_read` and `dm_wr` are 0. `ld_data`, `dm_addr`, `dm_wr_data` and the merge register are 16'h0000.
- Reset mid-access: strobes drop at that edge and no `done` is issued. A write already strobed stays in memory.
- Let A be the edge that accepts `req`, with S=`SETUP_CYCLES`. `done` is high in the cycle after the edge:
  - Word load, byte load, or word store: A+S+2.
  - Byte store: A+2S+4.
  - Error: A+0, i.e. DONE in the cycle right after acceptance.
- With S=1:
  - Load: `dm_read` is high in the cycle after edge A+1; `done` after edge A+3.
  - Word store: `dm_wr` is high after edge A+1; `done` after edge A+3.
- `ready`=0 from the acceptance edge until DONE returns to IDLE. `req` is ignored while `ready`=0, including during DONE. The earliest back-to-back acceptance is the cycle after `done`.
- `err` and `ld_data` are registered. `err` clears on the next acceptance.

## Test plan
- Reset, then word store `addr`=16'h0010, `st_data`=16'hBEEF (S=1) → `dm_wr` pulses one cycle after edge A+1 with `dm_addr`=16'h0010 stable ±1 cycle; `done` after edge A+3; then word load from 16'h0010 gives `ld_data`=16'hBEEF.
- Byte store `addr`=16'h0010, `st_data`=16'h1234 over 16'hBEEF → one `dm_read` then one `dm_wr` with `dm_wr_data`=16'hBE34; `done` after edge A+6.
- Byte load from 16'h0011 (byte 8'hBE) → `ld_signed`=1 gives 16'hFFBE; `ld_signed`=0 gives 16'h00BE.
- `req` with `addr`=16'hFFFF → `done`=1 and `err`=1 in the next cycle; no strobe at any point.
- `rst_n` low during RD_STB of a load → `dm_read`=0, `ready`=1 the next cycle, no `done`; a new load then completes normally.
- `req` held high through a whole access → exactly one access per `ready` window; second acceptance occurs one cycle after `done`; repeat with S=3 to confirm load `done` after edge A+5.

Source files
------------

// File: rtl/dmem_master.sv
// dmem_master: load/store sequencer for the multicycle 16-bit core.
// Converts one request at a time into edge-strobed data-memory cycles.
// Byte stores use read-modify-write; byte loads are sign/zero-extended.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | ready, waiting for req
//   SETUP    | address/data stable, strobes low, SETUP_CYCLES
//   RD_STB   | dm_read high for one cycle
//   RD_CAP   | capture dm_rdata (load result or merge source)
//   WR_SETUP | merged word on dm_wr_data, strobes low
//   WR_STB   | dm_wr high for one cycle
//   WR_HOLD  | dm_wr low, address/data still held
//   DONE     | done pulse, then back to IDLE
module dmem_master #(
  parameter int SETUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        op_store,
  input  logic        op_byte,
  input  logic        ld_signed,
  input  logic [15:0] addr,
  input  logic [15:0] st_data,
  output logic        done,
  output logic        err,
  output logic [15:0] ld_data,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wr_data,
  output logic        dm_read,
  output logic        dm_wr,
  input  logic [15:0] dm_rdata
);

  localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, RD_STB, RD_CAP, WR_SETUP, WR_STB, WR_HOLD, DONE
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_ready;
  logic        r_done;
  logic        r_err;
  logic        r_rd;
  logic        r_wr;
  logic        r_store;
  logic        r_byte;
  logic        r_sgn;
  logic [15:0] r_addr;
  logic [15:0] r_st_data;
  logic [15:0] r_merge;
  logic [15:0] r_ld_data;

  logic        w_cnt_last;
  logic [15:0] w_merge;

  assign w_cnt_last = (r_cnt == CW'(SETUP_CYCLES - 1));
  assign w_merge    = {dm_rdata[15:8], r_st_data[7:0]};

  assign ready      = r_ready;
  assign done       = r_done;
  assign err        = r_err;
  assign ld_data    = r_ld_data;
  assign dm_addr    = r_addr;
  assign dm_read    = r_rd;
  assign dm_wr      = r_wr;
  // Byte stores drive the merged word; word stores drive the latched data.
  // Both sources only change on acceptance or on entry to WR_SETUP.
  assign dm_wr_data = (r_store && r_byte) ? r_merge : r_st_data;

  // Access sequencer with registered strobes and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_store   <= 1'b0;
      r_byte    <= 1'b0;
      r_sgn     <= 1'b0;
      r_addr    <= 16'h0000;
      r_st_data <= 16'h0000;
      r_merge   <= 16'h0000;
      r_ld_data <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_ready   <= 1'b0;
            r_store   <= op_store;
            r_byte    <= op_byte;
            r_sgn     <= ld_signed;
            r_st_data <= st_data;
            r_cnt     <= '0;
            if (addr == 16'hFFFF) begin
              // addr+1 would fall off the array: reject without a strobe.
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_addr  <= addr;
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_store && !r_byte) begin
              r_wr    <= 1'b1;
              r_state <= WR_STB;
            end else begin
              r_rd    <= 1'b1;
              r_state <= RD_STB;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RD_STB: begin
          r_rd    <= 1'b0;
          r_state <= RD_CAP;
        end
        RD_CAP: begin
          if (r_store) begin
            r_merge <= w_merge;
            r_cnt   <= '0;
            r_state <= WR_SETUP;
          end else begin
            if (r_byte)
              r_ld_data <= {{8{dm_rdata[7] & r_sgn}}, dm_rdata[7:0]};
            else
              r_ld_data <= dm_rdata;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        WR_SETUP: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_wr    <= 1'b1;
            r_state <= WR_STB;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WR_STB: begin
          r_wr    <= 1'b0;
          r_state <= WR_HOLD;
        end
        WR_HOLD: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: directed bench for dmem_master with a byte-array memory
// model (S=1 instance) and a fixed-pattern responder (S=3 instance).
module tb_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req3 = 1'b0;
  logic        op_store = 1'b0;
  logic        op_byte = 1'b0;
  logic        ld_signed = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] st_data = 16'h0000;

  logic        ready, done, err, dm_read, dm_wr;
  logic [15:0] ld_data, dm_addr, dm_wr_data;
  logic [15:0] dm_rdata = 16'h0000;

  logic        ready3, done3, err3, dm_read3, dm_wr3;
  logic [15:0] ld_data3, dm_addr3, dm_wr_data3;
  logic [15:0] dm_rdata3 = 16'h0000;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_master #(.SETUP_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .op_store(op_store), .op_byte(op_byte), .ld_signed(ld_signed),
    .addr(addr), .st_data(st_data), .done(done), .err(err),
    .ld_data(ld_data), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .dm_read(dm_read), .dm_wr(dm_wr), .dm_rdata(dm_rdata)
  );

  dmem_master #(.SETUP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .ready(ready3),
    .op_store(op_store), .op_byte(op_byte), .ld_signed(ld_signed),
    .addr(addr), .st_data(st_data), .done(done3), .err(err3),
    .ld_data(ld_data3), .dm_addr(dm_addr3), .dm_wr_data(dm_wr_data3),
    .dm_read(dm_read3), .dm_wr(dm_wr3), .dm_rdata(dm_rdata3)
  );

  // Edge-strobed memory: little-endian word = {mem[a+1], mem[a]}.
  always @(posedge dm_read) dm_rdata <= {mem[dm_addr + 16'd1], mem[dm_addr]};
  always @(posedge dm_wr) begin
    mem[dm_addr]         <= dm_wr_data[7:0];
    mem[dm_addr + 16'd1] <= dm_wr_data[15:8];
  end

  // Responder for the S=3 instance: returns address xor 16'hA55A.
  always @(posedge dm_read3) dm_rdata3 <= dm_addr3 ^ 16'hA55A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one access on the S=1 instance; k counts cycles after edge A+k.
  task automatic access(input logic st, input logic byt, input logic sgn,
                        input logic [15:0] a, input logic [15:0] d,
                        output int dk, output int rk, output int wk,
                        output int nr, output int nw, output logic e,
                        output logic [15:0] ld, output logic [15:0] wd,
                        output logic abad, output logic pbad);
    @(negedge clk);
    op_store = st; op_byte = byt; ld_signed = sgn; addr = a; st_data = d;
    req = 1'b1;
    dk = -1; rk = -1; wk = -1; nr = 0; nw = 0; e = 1'b0;
    ld = 16'h0; wd = 16'h0; abad = 1'b0; pbad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
      if (dm_read) begin nr++; rk = k; end
      if (dm_wr) begin nw++; wk = k; wd = dm_wr_data; end
      if (dm_read && dm_wr) pbad = 1'b1;
      if (ready) pbad = 1'b1;
      if (a != 16'hFFFF && dm_addr != a) abad = 1'b1;
      if (done) begin dk = k; e = err; ld = ld_data; break; end
    end
  endtask

  initial begin
    int dk, rk, wk, nr, nw, nd, d1, d2, nrdy, rdyk;
    logic e, abad, pbad;
    logic [15:0] ld, wd;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_strobes", {dm_read, dm_wr}, 2'b00);
    chk("rst_ld_data", ld_data, 16'h0000);
    chk("rst_dm_addr", dm_addr, 16'h0000);
    chk("rst_dm_wr_data", dm_wr_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store 0x0010 <= BEEF
    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("wst_done_k", dk, 3);
    chk("wst_wr_k", wk, 1);
    chk("wst_nwr", nw, 1);
    chk("wst_nrd", nr, 0);
    chk("wst_wdata", wd, 16'hBEEF);
    chk("wst_err", e, 1'b0);
    chk("wst_addr_stable", abad, 1'b0);
    chk("wst_proto", pbad, 1'b0);
    chk("wst_mem", {mem[16'h0011], mem[16'h0010]}, 16'hBEEF);

    // Word load 0x0010
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("wld_done_k", dk, 3);
    chk("wld_rd_k", rk, 1);
    chk("wld_strobes", {nr[7:0], nw[7:0]}, 16'h0100);
    chk("wld_data", ld, 16'hBEEF);
    chk("wld_proto", pbad, 1'b0);

    // Byte store 0x0010 <= 34 over BEEF
    access(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("bst_done_k", dk, 6);
    chk("bst_rd_k", rk, 1);
    chk("bst_wr_k", wk, 4);
    chk("bst_strobes", {nr[7:0], nw[7:0]}, 16'h0101);
    chk("bst_wdata", wd, 16'hBE34);
    chk("bst_addr_stable", abad, 1'b0);
    chk("bst_proto", pbad, 1'b0);
    chk("bst_mem", {mem[16'h0011], mem[16'h0010]}, 16'hBE34);

    // Error request at 0xFFFF
    access(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("err_done_k", dk, 0);
    chk("err_flag", e, 1'b1);
    chk("err_strobes", {nr[7:0], nw[7:0]}, 16'h0000);
    chk("err_proto", pbad, 1'b0);
    nr = 0;
    repeat (3) begin @(negedge clk); if (dm_read || dm_wr) nr++; end
    chk("err_no_late_strobe", nr, 0);

    // Byte loads from 0x0011 (byte BE)
    access(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("bld_s_done_k", dk, 3);
    chk("bld_s_err_clear", e, 1'b0);
    chk("bld_s_data", ld, 16'hFFBE);
    access(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("bld_u_data", ld, 16'h00BE);

    // Reset while dm_read is high
    @(negedge clk);
    op_store = 1'b0; op_byte = 1'b0; addr = 16'h0010; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mrst_rd_before", dm_read, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_rd_drop", dm_read, 1'b0);
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_done", done, 1'b0);
    rst_n = 1'b1;
    nd = 0;
    repeat (5) begin @(negedge clk); if (done) nd++; end
    chk("mrst_no_done", nd, 0);
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, dk, rk, wk, nr, nw, e, ld, wd, abad, pbad);
    chk("mrst_reload_k", dk, 3);
    chk("mrst_reload_data", ld, 16'hBE34);

    // req held high through back-to-back word loads
    @(negedge clk);
    op_store = 1'b0; op_byte = 1'b0; addr = 16'h0010; req = 1'b1;
    d1 = -1; d2 = -1; nr = 0; nrdy = 0; rdyk = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dm_read && d2 < 0) nr++;
      if (ready && d2 < 0) begin nrdy++; rdyk = k; end
      if (done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) begin d2 = k; req = 1'b0; end
      end
    end
    req = 1'b0;
    chk("hold_done1_k", d1, 3);
    chk("hold_ready_k", rdyk, 4);
    chk("hold_ready_cnt", nrdy, 1);
    chk("hold_done2_k", d2, 8);
    chk("hold_nrd", nr, 2);

    // S=3 word load from 0x0020
    @(negedge clk);
    op_store = 1'b0; op_byte = 1'b0; addr = 16'h0020; req3 = 1'b1;
    dk = -1; rk = -1; ld = 16'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) req3 = 1'b0;
      if (dm_read3) rk = k;
      if (done3) begin dk = k; ld = ld_data3; break; end
    end
    chk("s3_rd_k", rk, 3);
    chk("s3_done_k", dk, 5);
    chk("s3_data", ld, 16'hA57A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
